// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file write controller: FSM state and width helper.
package regfile_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ZERO = 1'b1
  } state_t;

  // Index width that stays at least 1 bit even for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a
// registered pointer; the pointer moves past the winner when advance is high.
import regfile_ctrl_pkg::*;

module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         valid,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [idx_w(N)-1:0]  grant_idx
);

  localparam int PW = idx_w(N);

  logic [PW-1:0] ptr;

  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && valid[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        grant_idx    = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == PW'(N-1)) ? '0 : PW'(grant_idx + 1'b1);
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port controller: round-robin requester arbitration plus
// a zeroization sequencer. Every rf_* and zero_* output comes from a register.
import regfile_ctrl_pkg::*;

module regfile_wr_arbiter #(
  parameter  int REG_WIDTH = 32,
  parameter  int REG_COUNT = 16,
  parameter  int NUM_REQ   = 2,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*AW-1:0]          req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_data,
  input  logic                           zero_start,
  output logic                           zero_busy,
  output logic                           zero_done,
  output logic                           rf_we,
  output logic [AW-1:0]                  rf_w_addr,
  output logic [REG_WIDTH-1:0]           rf_w_data
);

  localparam int            PW   = idx_w(NUM_REQ);
  localparam logic [AW-1:0] LAST = AW'(REG_COUNT - 1);

  state_t                 state, state_n;
  logic [AW-1:0]          cnt, cnt_n;
  logic                   we_n, busy_n, done_n;
  logic [AW-1:0]          addr_n;
  logic [REG_WIDTH-1:0]   data_n;
  logic [NUM_REQ-1:0]     grant;
  logic [PW-1:0]          grant_idx;
  logic                   open, xfer;

  // A wipe request in IDLE pre-empts any grant in the same cycle.
  assign open      = !rst && (state == IDLE) && !zero_start;
  assign req_ready = open ? grant : '0;
  assign xfer      = |req_ready;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we_n    = 1'b0;
    addr_n  = rf_w_addr;
    data_n  = rf_w_data;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (zero_start) begin
          state_n = ZERO;
          cnt_n   = AW'(1);
          we_n    = 1'b1;
          addr_n  = '0;
          data_n  = '0;
          busy_n  = 1'b1;
        end else if (xfer) begin
          we_n   = 1'b1;
          addr_n = req_addr[int'(grant_idx)*AW +: AW];
          data_n = req_data[int'(grant_idx)*REG_WIDTH +: REG_WIDTH];
        end
      end
      ZERO: begin
        // zero_done marks the final wipe write is already on the port.
        if (zero_done) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          we_n   = 1'b1;
          addr_n = cnt;
          data_n = '0;
          busy_n = 1'b1;
          done_n = (cnt == LAST);
          cnt_n  = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rf_we     <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      zero_busy <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rf_we     <= we_n;
      rf_w_addr <= addr_n;
      rf_w_data <= data_n;
      zero_busy <= busy_n;
      zero_done <= done_n;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: vector table for arbitration, scripted wipe
// sequences, and a per-cycle queue of expected write-port contents.
module tb_regfile_wr_arbiter;

  localparam int RW = 32;
  localparam int RC = 16;
  localparam int NR = 2;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*RW-1:0]  req_data;
  logic              zero_start, zero_busy, zero_done;
  logic              rf_we;
  logic [AW-1:0]     rf_w_addr;
  logic [RW-1:0]     rf_w_data;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.REG_WIDTH(RW), .REG_COUNT(RC), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .zero_start(zero_start),
    .zero_busy(zero_busy), .zero_done(zero_done), .rf_we(rf_we),
    .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data)
  );

  // Register file fed by the write port.
  logic [RW-1:0] mem [RC];
  always @(posedge clk) if (rf_we) mem[rf_w_addr] <= rf_w_data;

  typedef struct {
    logic [1:0]    valid;
    logic [AW-1:0] a0, a1;
    logic [RW-1:0] d0, d1;
    logic [1:0]    rdy;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    logic          busy;
    logic          done;
  } exp_t;

  vec_t vecs [12];
  exp_t q [$];
  int   n_chk = 0, n_fail = 0;
  int   block = 0, skip = 0, busy_cnt = 0, done_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic check_out(input string nm);
    exp_t e;
    logic ok;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued", nm);
    end else begin
      e  = q.pop_front();
      ok = (rf_we === e.we) && (zero_busy === e.busy) && (zero_done === e.done) &&
           (!e.we || (rf_w_addr === e.addr && rf_w_data === e.data));
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: got we=%0b addr=%0h data=%0h busy=%0b done=%0b, expected we=%0b addr=%0h data=%0h busy=%0b done=%0b",
                 nm, rf_we, rf_w_addr, rf_w_data, zero_busy, zero_done,
                 e.we, e.addr, e.data, e.busy, e.done);
      end
    end
    if (zero_busy === 1'b1) busy_cnt++;
    if (zero_done === 1'b1) done_cnt++;
  endtask

  // Called at negedge+1: drive, check ready, queue next-cycle expectation, clock, check outputs.
  task automatic drive_cycle(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [RW-1:0] d0, input logic [RW-1:0] d1,
                             input logic zs, input logic [1:0] rdy, input string nm);
    logic [1:0] er;
    exp_t e;
    req_valid  = v;
    req_addr   = {a1, a0};
    req_data   = {d1, d0};
    zero_start = zs;
    er = (block > 0 || zs) ? 2'b00 : rdy;
    #1;
    check({nm, ".ready"}, 64'(req_ready), 64'(er));
    e = '{we: 1'b0, addr: '0, data: '0, busy: 1'b0, done: 1'b0};
    if (er == 2'b01) e = '{we: 1'b1, addr: a0, data: d0, busy: 1'b0, done: 1'b0};
    if (er == 2'b10) e = '{we: 1'b1, addr: a1, data: d1, busy: 1'b0, done: 1'b0};
    if (block > 0) begin
      block--;
      if (skip > 0) skip--;
      else q.push_back(e);
    end else if (zs) begin
      for (int k = 0; k < RC; k++)
        q.push_back('{we: 1'b1, addr: AW'(k), data: '0, busy: 1'b1, done: (k == RC-1)});
      block = RC;
      skip  = RC - 1;
    end else begin
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check_out({nm, ".out"});
  endtask

  task automatic do_reset(input string nm);
    rst        = 1'b1;
    req_valid  = 2'b11;
    zero_start = 1'b0;
    #1;
    check({nm, ".ready"}, 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check({nm, ".out"}, {rf_we, zero_busy, zero_done, rf_w_addr, rf_w_data}, 64'd0);
    rst       = 1'b0;
    req_valid = 2'b00;
    q.delete();
    block = 0;
    skip  = 0;
  endtask

  initial begin
    vecs[0]  = '{2'b11, 4'h1, 4'h2, 32'h0000_0101, 32'h0000_0202, 2'b01};
    vecs[1]  = '{2'b11, 4'h3, 4'h4, 32'h0000_0303, 32'h0000_0404, 2'b10};
    vecs[2]  = '{2'b11, 4'h5, 4'h6, 32'h0000_0505, 32'h0000_0606, 2'b01};
    vecs[3]  = '{2'b11, 4'h7, 4'h8, 32'h0000_0707, 32'h0000_0808, 2'b10};
    vecs[4]  = '{2'b00, 4'h0, 4'h0, 32'h0,         32'h0,         2'b00};
    vecs[5]  = '{2'b10, 4'h0, 4'h9, 32'h0,         32'h0000_0909, 2'b10};
    vecs[6]  = '{2'b11, 4'hA, 4'hB, 32'h0000_0A0A, 32'h0000_0B0B, 2'b01};
    vecs[7]  = '{2'b01, 4'hC, 4'hD, 32'h0000_0C0C, 32'h0000_0D0D, 2'b01};
    vecs[8]  = '{2'b11, 4'hE, 4'hF, 32'h0000_0E0E, 32'h0000_0F0F, 2'b10};
    vecs[9]  = '{2'b11, 4'h2, 4'h3, 32'h2222_2222, 32'hA5A5_A5A5, 2'b01};
    vecs[10] = '{2'b10, 4'h2, 4'h3, 32'h2222_2222, 32'hA5A5_A5A5, 2'b10};
    vecs[11] = '{2'b00, 4'h0, 4'h0, 32'h0,         32'h0,         2'b00};

    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; zero_start = 1'b0;
    @(negedge clk);
    #1;
    do_reset("reset");

    // Fairness, idle pointer hold, and backpressure on requester 1.
    foreach (vecs[i])
      drive_cycle(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1,
                  1'b0, vecs[i].rdy, $sformatf("vec%0d", i));
    check("bp.r3", 64'(mem[3]), 64'hA5A5_A5A5);

    // Preload, then a full wipe.
    drive_cycle(2'b01, 4'h5, 4'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2'b01, "pre5");
    drive_cycle(2'b10, 4'h0, 4'hF, 32'h0, 32'h1234_5678, 1'b0, 2'b10, "pre15");
    drive_cycle(2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 2'b00, "pre_idle");
    check("pre.r5", 64'(mem[5]), 64'hDEAD_BEEF);
    check("pre.r15", 64'(mem[15]), 64'h1234_5678);
    busy_cnt = 0; done_cnt = 0;
    drive_cycle(2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2'b00, "wipe_start");
    for (int k = 0; k < RC; k++)
      drive_cycle(2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 2'b00, $sformatf("wipe%0d", k));
    check("wipe.busy_cycles", 64'(busy_cnt), 64'(RC));
    check("wipe.done_pulses", 64'(done_cnt), 64'd1);
    begin
      int nz = 0;
      for (int k = 0; k < RC; k++) if (mem[k] !== '0) nz++;
      check("wipe.nonzero_regs", 64'(nz), 64'd0);
    end

    // Start collides with a request; a second start mid-wipe is ignored.
    busy_cnt = 0; done_cnt = 0;
    drive_cycle(2'b10, 4'h0, 4'h9, 32'h0, 32'hCAFE_F00D, 1'b1, 2'b00, "coll_start");
    for (int k = 0; k < RC; k++)
      drive_cycle(2'b10, 4'h0, 4'h9, 32'h0, 32'hCAFE_F00D, (k == 4), 2'b00, $sformatf("coll%0d", k));
    drive_cycle(2'b10, 4'h0, 4'h9, 32'h0, 32'hCAFE_F00D, 1'b0, 2'b10, "coll_grant");
    drive_cycle(2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 2'b00, "coll_idle");
    check("coll.busy_cycles", 64'(busy_cnt), 64'(RC));
    check("coll.done_pulses", 64'(done_cnt), 64'd1);
    check("coll.r9", 64'(mem[9]), 64'hCAFE_F00D);

    // Reset while address 7 is being wiped.
    for (int i = 8; i < RC; i++)
      drive_cycle(2'b11, AW'(i), AW'(i), RW'(32'h100 + i), RW'(32'h100 + i), 1'b0,
                  (i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("load%0d", i));
    drive_cycle(2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 2'b00, "load_idle");
    drive_cycle(2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2'b00, "abort_start");
    for (int k = 1; k < 8; k++)
      drive_cycle(2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 2'b00, $sformatf("abort%0d", k));
    check("abort.addr_at_reset", 64'(rf_w_addr), 64'd7);
    do_reset("abort_reset");
    begin
      int bad = 0;
      for (int k = 0; k < 8; k++) if (mem[k] !== '0) bad++;
      for (int k = 8; k < RC; k++) if (mem[k] !== RW'(32'h100 + k)) bad++;
      check("abort.reg_contents", 64'(bad), 64'd0);
    end
    drive_cycle(2'b01, 4'h1, 4'h0, 32'h0000_0077, 32'h0, 1'b0, 2'b01, "post_abort");
    drive_cycle(2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 2'b00, "post_idle");
    check("post.r1", 64'(mem[1]), 64'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port controller for the processor's register file. It shares the single synchronous write port among `NUM_REQ` requesters (e.g. crypto core writeback, host key loader) using round-robin arbitration and valid/ready handshakes. It also provides a zeroization sequencer that wipes every register to zero on command, for key erasure. All register-file write-port signals leave this block from registers.

## Interface
Parameters:
- `REG_WIDTH`, default 32: register data width.
- `REG_COUNT`, default 16: number of registers. Must be a power of two, ≥2.
- `NUM_REQ`, default 2: number of write requesters, ≥2.
- `AW`, localparam = `$clog2(REG_COUNT)`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_valid`, in, `NUM_REQ`: per-requester write request.
- `req_ready`, out, `NUM_REQ`: per-requester accept.
- `req_addr`, in, `NUM_REQ*AW`: flattened addresses; requester i uses bits `[i*AW +: AW]`.
- `req_data`, in, `NUM_REQ*REG_WIDTH`: flattened data; requester i uses bits `[i*REG_WIDTH +: REG_WIDTH]`.
- `zero_start`, in, 1: request a full wipe.
- `zero_busy`, out, 1: wipe in progress.
- `zero_done`, out, 1: one-cycle pulse on the final wipe write.
- `rf_we`, out, 1: register-file write enable.
- `rf_w_addr`, out, `AW`: register-file write address.
- `rf_w_data`, out, `REG_WIDTH`: register-file write data.

## Operation
- **States:** IDLE and ZERO. Reset puts the block in IDLE with the round-robin pointer at 0, counter at 0, and `rf_we`, `rf_w_addr`, `rf_w_data`, `zero_busy` and `zero_done` all 0. `req_ready` is 0 during reset.
- **IDLE, arbitration:**
  - The grant goes to the first asserted `req_valid[i]`, searching from the pointer upward modulo `NUM_REQ`.
  - `req_ready[i]` = grant[i]. It is combinational from `req_valid`, and at most one bit is high.
  - A transfer occurs when valid & ready. At that edge the output registers load `rf_we`=1 and the requester's addr/data, and the pointer becomes (i+1) mod `NUM_REQ`.
  - A cycle with no transfer loads `rf_we`=0 and leaves the pointer unchanged.
- **Requester rule:** a requester must hold addr/data stable while valid & !ready. It may not withdraw valid before the transfer.
- **IDLE with `zero_start`=1:**
  - Zeroization wins: all `req_ready` are 0 that cycle.
  - At the edge: outputs load (`rf_we`=1, addr 0, data 0), counter←1, state←ZERO.
- **ZERO:**
  - `zero_busy`=1 and all `req_ready`=0.
  - Each edge loads (1, counter, 0) and increments the counter.
  - The write to address `REG_COUNT-1` is the last. `zero_done`=1 during the cycle that address is on `rf_w_addr`.
  - The next edge returns to IDLE with `rf_we`=0 and counter 0.
- **`zero_start` during ZERO:** ignored; no restart and no extension.
- **Reset mid-wipe:** the wipe aborts, the state returns to IDLE and outputs clear. The wipe is incomplete; software must reissue `zero_start`.
- **Address width:** addresses wrap naturally in `AW` bits. The counter is `AW` bits and the terminal check is against `REG_COUNT-1`, with no overflow.

## Timing
- **Request latency:** a transfer at edge E drives `rf_we`=1 in the cycle after E. The register file captures the write at edge E+1, and the data is readable after E+1.
- **Throughput:** one write per cycle sustained, with back-to-back grants allowed.
- **`zero_busy` duration:** high for exactly `REG_COUNT` cycles, namely the cycles in which zero writes are on `rf_*`.
  - The wipe occupies `REG_COUNT` cycles, from the cycle after `zero_start` is sampled through the cycle with `zero_done`.
  - The earliest new grant is the cycle after `zero_done`.
- **Collisions:** a wipe write and a requester write never share an output cycle. Requests accepted before `zero_start` complete first, because they are already in the output register.
- **No combinational path** from any input to the `rf_*` outputs, `zero_busy` or `zero_done`.

## Structure
- **Shared package `regfile_ctrl_pkg`:**
  - state enum (IDLE, ZERO);
  - a helper function for the address width, if the toolflow requires it.
- **Sub-module `rr_arbiter`:** parameterized by N; combinational one-hot grant from valid + pointer, plus a registered pointer update on an `advance` input.
- **Top level:** the FSM, the wipe counter, the output registers and the flattened-port muxing.

## Test plan
- **Round-robin fairness:** after reset, both requesters hold valid continuously (`NUM_REQ`=2).
  - Grants alternate 0,1,0,1.
  - `rf_w_addr`/`rf_w_data` match each requester one cycle after its transfer.
  - One write occurs per cycle.
- **Full wipe:** preload R5=0xDEADBEEF and R15=0x12345678, then pulse `zero_start` in IDLE.
  - `zero_busy` is high for 16 cycles, with `rf_w_addr` stepping 0..15 and data 0.
  - `zero_done` pulses with addr 15, and every register reads 0 afterwards.
- **Simultaneous start and request:** `zero_start` and `req_valid[1]` rise in the same cycle.
  - `req_ready`=0 for that cycle and for the entire wipe.
  - Requester 1 is granted in the first cycle after `zero_done`, and its write lands after the wipe.
- **Backpressure stability:** requester 0 is granted while requester 1 is waiting with addr 3 and data 0xA5A5A5A5 held.
  - Requester 1 is accepted next, and `rf` receives addr 3, data 0xA5A5A5A5 exactly once.
- **Reset mid-wipe:** assert `rst` when `rf_w_addr`=7 during a wipe.
  - The next cycle shows `rf_we`=0, `zero_busy`=0, and the state back in IDLE.
  - Registers 8..15 keep their prior values.
- **Ignored restart:** a second `zero_start` at wipe cycle 4.
  - The wipe length stays 16 cycles with a single `zero_done` pulse.
